// File: rtl/mixer_multi.sv
// mixer_multi: N-channel stereo PCM mixer with three 1-bit sources and
// per-side first-order sigma-delta outputs.
// One shared multiply-accumulate is time-multiplexed over a frame of
// CHANNELS+3 clk28 cycles:
//   phases 0..CHANNELS-1 : PCM channel k, scaled by vol_l[k] / vol_r[k]
//   phase  CHANNELS      : beeper   (full code, max volume)
//   phase  CHANNELS+1    : tape_out (2^(DW-2), max volume)
//   phase  CHANNELS+2    : tape_in  (2^(DW-3), max volume)
// Ports:
//   clk28, rst            clock, synchronous active-high reset
//   ch_data               packed PCM inputs, channel k at [k*DW +: DW]
//   beeper/tape_out/tape_in 1-bit sources
//   mono                  both outputs carry floor((L+R)/2)
//   cfg_we/cfg_ch/cfg_vol_l/cfg_vol_r  volume register write port
//   sample_l/sample_r     latest mixed frame
//   frame_stb             one-cycle pulse when sample_* update
//   dac_l/dac_r           sigma-delta bitstreams
module mixer_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned VOLW     = 4,
  parameter int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned SW      = DW + VOLW + $clog2(CHANNELS + 3)
) (
  input  logic                   clk28,
  input  logic                   rst,
  input  logic [CHANNELS*DW-1:0] ch_data,
  input  logic                   beeper,
  input  logic                   tape_out,
  input  logic                   tape_in,
  input  logic                   mono,
  input  logic                   cfg_we,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [VOLW-1:0]        cfg_vol_l,
  input  logic [VOLW-1:0]        cfg_vol_r,
  output logic [SW-1:0]          sample_l,
  output logic [SW-1:0]          sample_r,
  output logic                   frame_stb,
  output logic                   dac_l,
  output logic                   dac_r
);

  localparam int unsigned F  = CHANNELS + 3;
  localparam int unsigned PW = $clog2(F);

  localparam logic [PW-1:0]   LAST_PHASE = PW'(F - 1);
  localparam logic [VOLW-1:0] VMAX       = '1;
  localparam logic [DW-1:0]   BEEP_LVL   = '1;
  localparam logic [DW-1:0]   TOUT_LVL   = DW'(1) << (DW - 2);
  localparam logic [DW-1:0]   TIN_LVL    = DW'(1) << (DW - 3);

  logic [PW-1:0]   phase;
  logic [SW-1:0]   acc_l, acc_r;
  logic [SW-1:0]   sd_l, sd_r;
  logic [VOLW-1:0] vol_l [CHANNELS];
  logic [VOLW-1:0] vol_r [CHANNELS];

  logic [DW-1:0]   src_c;
  logic [VOLW-1:0] vsel_l_c, vsel_r_c;
  logic [SW-1:0]   sum_l_c, sum_r_c, avg_c;
  logic [SW:0]     sd_l_next_c, sd_r_next_c;

  // Select this phase's source level and volumes; virtual sources run at max volume.
  always_comb begin
    src_c    = '0;
    vsel_l_c = VMAX;
    vsel_r_c = VMAX;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (phase == PW'(k)) begin
        src_c    = ch_data[k*DW +: DW];
        vsel_l_c = vol_l[k];
        vsel_r_c = vol_r[k];
      end
    end
    if (phase == PW'(CHANNELS))     src_c = beeper   ? BEEP_LVL : '0;
    if (phase == PW'(CHANNELS + 1)) src_c = tape_out ? TOUT_LVL : '0;
    if (phase == PW'(CHANNELS + 2)) src_c = tape_in  ? TIN_LVL  : '0;
  end

  // Running sums including this phase's term; SW is sized so these never overflow.
  always_comb begin
    sum_l_c = acc_l + SW'(src_c) * SW'(vsel_l_c);
    sum_r_c = acc_r + SW'(src_c) * SW'(vsel_r_c);
    avg_c   = SW'(({1'b0, sum_l_c} + {1'b0, sum_r_c}) >> 1);
  end

  // First-order sigma-delta: the carry out of residual+sample is the output bit.
  always_comb begin
    sd_l_next_c = {1'b0, sd_l} + {1'b0, sample_l};
    sd_r_next_c = {1'b0, sd_r} + {1'b0, sample_r};
  end

  // Phase sequencing, accumulation, frame latch, volume writes, modulator state.
  always_ff @(posedge clk28) begin
    if (rst) begin
      phase     <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      sample_l  <= '0;
      sample_r  <= '0;
      frame_stb <= 1'b0;
      sd_l      <= '0;
      sd_r      <= '0;
      dac_l     <= 1'b0;
      dac_r     <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        vol_l[k] <= VMAX;
        vol_r[k] <= VMAX;
      end
    end else begin
      if (phase == LAST_PHASE) begin
        phase     <= '0;
        acc_l     <= '0;
        acc_r     <= '0;
        sample_l  <= mono ? avg_c : sum_l_c;
        sample_r  <= mono ? avg_c : sum_r_c;
        frame_stb <= 1'b1;
      end else begin
        phase     <= phase + PW'(1);
        acc_l     <= sum_l_c;
        acc_r     <= sum_r_c;
        frame_stb <= 1'b0;
      end

      sd_l  <= sd_l_next_c[SW-1:0];
      sd_r  <= sd_r_next_c[SW-1:0];
      dac_l <= sd_l_next_c[SW];
      dac_r <= sd_r_next_c[SW];

      // Out-of-range indices match no register and are dropped.
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (cfg_we && (cfg_ch == CW'(k))) begin
          vol_l[k] <= cfg_vol_l;
          vol_r[k] <= cfg_vol_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_mixer_multi.sv
// Testbench for mixer_multi: a two-channel instance (F=5, SW=15) carries the
// main directed vectors, a three-channel instance (F=6) covers an
// out-of-range volume write. Expected frames are queued by the stimulus and
// popped by per-instance monitors on frame_stb.
module tb_mixer_multi;

  localparam int unsigned F2 = 5;
  localparam int unsigned F3 = 6;

  typedef struct {
    bit          chk;
    logic [14:0] l;
    logic [14:0] r;
  } exp_t;

  logic clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Two-channel instance
  logic        rst;
  logic [15:0] ch_data;
  logic        beeper, tape_out, tape_in, mono;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [3:0]  cfg_vol_l, cfg_vol_r;
  logic [14:0] sample_l, sample_r;
  logic        frame_stb, dac_l, dac_r;

  // Three-channel instance
  logic        rst3;
  logic [23:0] ch_data3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [3:0]  cfg_vl3, cfg_vr3;
  logic [14:0] sample3_l, sample3_r;
  logic        frame_stb3, dac3_l, dac3_r;

  mixer_multi #(.CHANNELS(2), .DW(8), .VOLW(4)) u_dut (
    .clk28     (clk28),
    .rst       (rst),
    .ch_data   (ch_data),
    .beeper    (beeper),
    .tape_out  (tape_out),
    .tape_in   (tape_in),
    .mono      (mono),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_vol_l (cfg_vol_l),
    .cfg_vol_r (cfg_vol_r),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .frame_stb (frame_stb),
    .dac_l     (dac_l),
    .dac_r     (dac_r)
  );

  mixer_multi #(.CHANNELS(3), .DW(8), .VOLW(4)) u_dut3 (
    .clk28     (clk28),
    .rst       (rst3),
    .ch_data   (ch_data3),
    .beeper    (1'b0),
    .tape_out  (1'b0),
    .tape_in   (1'b0),
    .mono      (1'b0),
    .cfg_we    (cfg_we3),
    .cfg_ch    (cfg_ch3),
    .cfg_vol_l (cfg_vl3),
    .cfg_vol_r (cfg_vr3),
    .sample_l  (sample3_l),
    .sample_r  (sample3_r),
    .frame_stb (frame_stb3),
    .dac_l     (dac3_l),
    .dac_r     (dac3_r)
  );

  exp_t q2[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor, two-channel instance: frame spacing and queued sample values.
  int since2       = 0;
  bit dac_zero_chk = 1'b0;
  int dac_hi       = 0;
  always @(posedge clk28) begin
    exp_t e;
    #1;
    if (dac_zero_chk && (dac_l || dac_r)) dac_hi++;
    if (rst) begin
      since2 = 0;
    end else begin
      since2++;
      if (frame_stb) begin
        check("frame_period", 32'(since2), 32'(F2));
        since2 = 0;
        if (q2.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: frame_stb with no queued frame, expected none");
        end else begin
          e = q2.pop_front();
          if (e.chk) begin
            check("sample_l", 32'(sample_l), 32'(e.l));
            check("sample_r", 32'(sample_r), 32'(e.r));
          end
        end
      end
    end
  end

  // Monitor, three-channel instance.
  int since3 = 0;
  always @(posedge clk28) begin
    exp_t e;
    #1;
    if (rst3) begin
      since3 = 0;
    end else begin
      since3++;
      if (frame_stb3) begin
        check("frame3_period", 32'(since3), 32'(F3));
        since3 = 0;
        if (q3.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame3: frame_stb with no queued frame, expected none");
        end else begin
          e = q3.pop_front();
          if (e.chk) begin
            check("sample3_l", 32'(sample3_l), 32'(e.l));
            check("sample3_r", 32'(sample3_r), 32'(e.r));
          end
        end
      end
    end
  end

  // Count dac_l ones over a fixed window.
  bit sd_en   = 1'b0;
  int sd_cyc  = 0;
  int sd_ones = 0;
  always @(posedge clk28) begin
    #1;
    if (sd_en && (sd_cyc < 4096)) begin
      sd_cyc++;
      if (dac_l) sd_ones++;
    end
  end

  // One frame on the two-channel instance, starting at the negedge of its phase-0 cycle.
  // wp selects the phase in which a volume write is issued (-1 = none).
  task automatic frame2(input logic [15:0] d, input logic [2:0] src, input logic m,
                        input int wp, input logic wch, input logic [3:0] wl, input logic [3:0] wr,
                        input bit chk, input logic [14:0] el, input logic [14:0] er);
    exp_t e;
    ch_data = d;
    {beeper, tape_out, tape_in} = src;
    mono      = m;
    cfg_ch    = wch;
    cfg_vol_l = wl;
    cfg_vol_r = wr;
    e.chk = chk;
    e.l   = el;
    e.r   = er;
    q2.push_back(e);
    for (int p = 0; p < int'(F2); p++) begin
      cfg_we = (p == wp);
      @(negedge clk28);
    end
    cfg_we = 1'b0;
  endtask

  task automatic frame3(input logic [23:0] d, input int wp, input logic [1:0] wch,
                        input logic [3:0] wl, input logic [3:0] wr,
                        input bit chk, input logic [14:0] el, input logic [14:0] er);
    exp_t e;
    ch_data3 = d;
    cfg_ch3  = wch;
    cfg_vl3  = wl;
    cfg_vr3  = wr;
    e.chk = chk;
    e.l   = el;
    e.r   = er;
    q3.push_back(e);
    for (int p = 0; p < int'(F3); p++) begin
      cfg_we3 = (p == wp);
      @(negedge clk28);
    end
    cfg_we3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  ch_data = '0; beeper = 1'b0; tape_out = 1'b0; tape_in = 1'b0;
    mono = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_vol_l = '0; cfg_vol_r = '0;
    rst3 = 1'b1; ch_data3 = '0; cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_vl3 = '0; cfg_vr3 = '0;
    repeat (3) @(negedge clk28);

    // Three channels: write to index 3 must be dropped; a legal write then takes effect.
    check("rst3_sample_l", 32'(sample3_l), 32'd0);
    rst3 = 1'b0;
    frame3(24'h000000,  0, 2'd3, 4'd0, 4'd0, 1'b1, 15'd0,   15'd0);
    frame3(24'h101010,  5, 2'd2, 4'd1, 4'd2, 1'b1, 15'd720, 15'd720);
    frame3(24'h101010, -1, 2'd0, 4'd0, 4'd0, 1'b1, 15'd496, 15'd512);
    rst3 = 1'b1;
    repeat (2) @(negedge clk28);

    // Reset values while rst is held.
    check("rst_sample_l",  32'(sample_l),  32'd0);
    check("rst_sample_r",  32'(sample_r),  32'd0);
    check("rst_frame_stb", 32'(frame_stb), 32'd0);
    check("rst_dac_l",     32'(dac_l),     32'd0);
    check("rst_dac_r",     32'(dac_r),     32'd0);

    // Silence: zero samples, dac outputs stay low.
    rst = 1'b0;
    dac_zero_chk = 1'b1;
    repeat (3) frame2(16'h0000, 3'b000, 1'b0, -1, 1'b0, 4'd0, 4'd0, 1'b1, 15'd0, 15'd0);
    dac_zero_chk = 1'b0;
    check("dac_idle_zero", 32'(dac_hi), 32'd0);

    // Full scale on everything at default volumes.
    repeat (2) frame2(16'hFFFF, 3'b111, 1'b0, -1, 1'b0, 4'd0, 4'd0, 1'b1, 15'd12915, 15'd12915);

    // Stereo volumes, mono averaging including an odd sum.
    frame2(16'h2010, 3'b000, 1'b0,  0, 1'b0, 4'd15, 4'd0, 1'b0, 15'd0, 15'd0);
    frame2(16'h2010, 3'b000, 1'b0,  0, 1'b1, 4'd0,  4'd8, 1'b0, 15'd0, 15'd0);
    frame2(16'h2010, 3'b000, 1'b0, -1, 1'b0, 4'd0,  4'd0, 1'b1, 15'd240, 15'd256);
    frame2(16'h2010, 3'b000, 1'b1, -1, 1'b0, 4'd0,  4'd0, 1'b1, 15'd248, 15'd248);
    frame2(16'h2011, 3'b000, 1'b1, -1, 1'b0, 4'd0,  4'd0, 1'b1, 15'd255, 15'd255);
    frame2(16'h2011, 3'b000, 1'b0, -1, 1'b0, 4'd0,  4'd0, 1'b1, 15'd255, 15'd256);

    // Write collision: phase-1 write to ch1 uses the old volume for that frame.
    frame2(16'h1000, 3'b000, 1'b0,  0, 1'b1, 4'd15, 4'd15, 1'b1, 15'd240, 15'd240);
    frame2(16'h1000, 3'b000, 1'b0,  1, 1'b1, 4'd0,  4'd0,  1'b1, 15'd240, 15'd240);
    frame2(16'h1000, 3'b000, 1'b0, -1, 1'b0, 4'd0,  4'd0,  1'b1, 15'd0,   15'd0);

    // Sigma-delta duty: L = 255*13 + 92*1 + 3825 + 960 = 8192 -> 1/4 of 2^15.
    frame2(16'h5CFF, 3'b110, 1'b0, 0, 1'b0, 4'd13, 4'd15, 1'b0, 15'd0, 15'd0);
    frame2(16'h5CFF, 3'b110, 1'b0, 0, 1'b1, 4'd1,  4'd15, 1'b0, 15'd0, 15'd0);
    for (int i = 0; i < 825; i++) begin
      if (i == 2) sd_en = 1'b1;
      frame2(16'h5CFF, 3'b110, 1'b0, -1, 1'b0, 4'd0, 4'd0, 1'b1, 15'd8192, 15'd9990);
    end
    sd_en = 1'b0;
    check("sd_window_cycles", 32'(sd_cyc), 32'd4096);
    n_checks++;
    if ((sd_ones < 1023) || (sd_ones > 1025)) begin
      n_fail++;
      $display("FAIL sd_duty: got %0d ones, expected 1024 +/- 1", sd_ones);
    end

    // Reset in phase 2 of a loud frame; the next frame must use only new inputs and default volumes.
    ch_data = 16'hFFFF;
    {beeper, tape_out, tape_in} = 3'b111;
    repeat (2) @(negedge clk28);
    rst = 1'b1;
    @(negedge clk28);
    rst = 1'b0;
    frame2(16'h0201, 3'b000, 1'b0, -1, 1'b0, 4'd0, 4'd0, 1'b1, 15'd45, 15'd45);

    check("queue2_drained", 32'(q2.size()), 32'd0);
    check("queue3_drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mixer_multi.md
# mixer_multi

Parametrised successor to the fixed four-channel sound mixer. It mixes N unsigned PCM channels (Covox/Soundrive, future DAC sources) plus the three 1-bit sources (beeper, tape out, tape in) into left/right sums using per-channel stereo volumes. One shared multiplier-accumulator is time-multiplexed on clk28. Each side then drives a first-order sigma-delta output to the snd_l/snd_r pins.

## Interface
Parameters:
- CHANNELS, 4, number of PCM channels (1..16)
- DW, 8, PCM sample width
- VOLW, 4, volume width; volume v scales by v (0 = mute, 2^VOLW-1 = max)
- CW, $clog2(CHANNELS), config channel index width (min 1)
- SW, DW+VOLW+$clog2(CHANNELS+3), sum width (derived, not overridable)

Ports:
- clk28  in  1  system clock
- rst  in  1  synchronous reset, active-high (sampled on clk28 rising edge)
- ch_data  in  CHANNELS*DW  channel k at bits [k*DW +: DW], unsigned
- beeper, tape_out, tape_in  in  1 each  1-bit sources
- mono  in  1  1 = both outputs carry the L/R average
- cfg_we  in  1  volume write strobe
- cfg_ch  in  CW  channel index for the write
- cfg_vol_l, cfg_vol_r  in  VOLW each  new volumes
- sample_l, sample_r  out  SW each  latest mixed frame
- frame_stb  out  1  one-cycle pulse; sample_* just updated
- dac_l, dac_r  out  1 each  sigma-delta bitstreams

## Operation
- Phase counter runs 0..F-1 and wraps, with F = CHANNELS+3. Frame = F cycles.
- PCM phases:
  - Phase p < CHANNELS: acc_l += ch_data[p]*vol_l[p] and acc_r += ch_data[p]*vol_r[p].
  - ch_data is sampled in its own phase cycle only. No snapshot.
- Virtual channels always use volume 2^VOLW-1 on both sides:
  - phase CHANNELS: beeper ? {DW{1}} : 0
  - phase CHANNELS+1: tape_out ? 2^(DW-2) : 0
  - phase CHANNELS+2: tape_in ? 2^(DW-3) : 0
- Phase F-1 end of frame:
  - The final sum (acc plus this phase's term) loads into sample_l/sample_r.
  - acc_l/acc_r clear to 0.
  - If mono=1, both samples load floor((sum_l+sum_r)/2) instead. mono is sampled at phase F-1.
- No overflow is possible: SW holds F*(2^DW-1)*(2^VOLW-1). No saturation logic.
- Volume registers: vol_l[k], vol_r[k], VOLW bits each.
  - A cfg_we write lands on the clock edge.
  - If the write targets the channel being accumulated in that same cycle, the old value is used for that cycle.
  - cfg_ch >= CHANNELS is ignored.
- Sigma-delta, per side, runs every clk28 cycle:
  - sd = sd[SW-1:0] + sample, in an SW+1-bit accumulator.
  - dac = sd[SW] (the carry), registered.
  - Long-run duty of dac = sample/2^SW.

## Timing
- Reset (rst=1 on a clock edge):
  - phase, acc_l, acc_r, sd_l, sd_r, sample_l, sample_r = 0
  - frame_stb = 0; dac_l = dac_r = 0
  - all volumes = 2^VOLW-1
- After reset release, the first cycle is phase 0.
- Reset asserted mid-frame discards the partial frame. No frame_stb for it.
- frame_stb is high exactly the cycle after the phase F-1 edge, i.e. once per F cycles. sample_* are stable from that cycle for F cycles.
- Latency from channel p being sampled to sample_* valid: F-p cycles.
- The sigma-delta sees a new sample on the cycle frame_stb is high. dac changes at most once per clock.
- CHANNELS=1 is legal: CW=1, only index 0 is writable, F=4.

## Test plan
- Reset defaults, CHANNELS=2, DW=8, VOLW=4 (F=5, SW=15):
  - all inputs 0, release rst.
  - Required: frame_stb at cycles 5, 10, 15…; sample_l = sample_r = 0; dac_l = dac_r = 0 constantly.
- Full scale:
  - ch0 = ch1 = 0xFF, beeper = tape_out = tape_in = 1, default volumes.
  - Required: sample = 255*15*2 + 255*15 + 64*15 + 32*15 = 12915 on both sides.
- Stereo volume:
  - write ch0 vol_l=15, vol_r=0 and ch1 vol_l=0, vol_r=8; ch0=0x10, ch1=0x20, 1-bit sources 0.
  - Required: sample_l = 240, sample_r = 256.
  - Then mono=1: required sample_l = sample_r = 248.
- Write collision and ignored write:
  - cfg_we to ch1 (vol 0) in the same cycle as phase 1; ch1 = 0x10, others 0.
  - Required: that frame includes 0x10*15 = 240; the next frame gives 0.
  - cfg_ch = 3 (out of range, CW=1 wraps to index 1?) — instead use CHANNELS=3 with cfg_ch = 3: no volume changes.
- Sigma-delta duty:
  - force sample_l = 8192 (ch0 = 0xFF at volume 15 gives 3825; use parameters/levels giving 8192), run 4096 cycles.
  - Required: count of dac_l = 1 is exactly 1024 ±1.
- Reset mid-frame:
  - assert rst at phase 2 for one cycle with non-zero inputs.
  - Required: no frame_stb until 5 cycles after release; first post-reset sample is computed entirely from post-reset inputs.
